multicycle_rv_ctrl: RTL
=======================

// Module: multicycle_rv_ctrl
// PURPOSE
//  Parametrised multicycle RV32I control FSM; drives the shared-memory datapath (PC, IR, regfile, ALU, result mux).
//  Successor to the fixed-latency controller: memory handshake with wait states and timeout, full branch/shift/AUIPC decode.
//  Also provides illegal-opcode trapping and a retired-instruction counter. Sits between the IR fields and the datapath selects.
// PARAMETERS
//  MAX_WAIT   16  cycles a memory access may wait for mem_ready before timeout trap (1..255)
//  INSTRET_W  32  width of retired-instruction counter
//  EN_SHIFT   1   1: decode SLL/SRL/SRA(+I); 0: these encodings trap as illegal
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   async active-low reset
//  op         in   7   IR[6:0];  funct3 in 3 IR[14:12];  funct7 in 7 IR[31:25]
//  zero,lt,ltu in  1   ALU flags: A==B, signed A<B, unsigned A<B (valid in BRANCH)
//  mem_ready  in   1   memory completes current access this cycle
//  pc_we,ir_we,reg_we,mem_we,mem_re out 1  strobes; adr_src out 1 (0 PC, 1 ALUOut)
//  res_src    out  2   0 ALUOut, 1 MDR, 2 ALU result, 3 imm
//  alu_src_a  out  2   0 PC, 1 OldPC, 2 rs1;  alu_src_b out 2  0 rs2, 1 imm, 2 const 4
//  alu_op     out  4   0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLTU 7 SLL 8 SRL 9 SRA
//  imm_src    out  3   0 I 1 S 2 B 3 J 4 U
//  trap       out  1   sticky: illegal instr (cause=0) or mem timeout (cause=1); cause out 1
//  instret    out  INSTRET_W  retired-instruction count
// BEHAVIOUR
//  - rst_n low: state=FETCH, wait_cnt=0, instret=0, trap=0, cause=0; all strobes forced 0 while rst_n low.
//  - Moore outputs from state; only pc_we/ir_we/reg_we(MEM_WB) and state advance are gated by mem_ready / flags.
//  - FETCH: mem_re=1, adr_src=0, A=PC, B=4, ADD, res_src=2; on mem_ready: ir_we=1, pc_we=1 -> DECODE; else stay.
//  - DECODE: A=OldPC, B=imm(B), ADD (branch target to ALUOut). Next by op:
//    0110011 EXEC_R, 0010011 EXEC_I, 0000011/0100011 MEM_ADDR, 1100011 BRANCH, 1101111 JAL,
//    1100111 JALR, 0110111 LUI, 0010111 AUIPC, other -> TRAP(cause 0). Undefined funct3/funct7 in R/I -> TRAP.
//  - EXEC_R/EXEC_I: A=rs1, B=rs2/imm(I), alu_op from funct3/funct7[5] -> ALU_WB. SRAI uses funct7[5]=1.
//  - ALU_WB: res_src=0, reg_we=1 -> FETCH (retire).
//  - MEM_ADDR: A=rs1, B=imm(I for load, S for store), ADD -> MEM_RD or MEM_WR.
//  - MEM_RD: adr_src=1, mem_re=1; on mem_ready -> MEM_WB. MEM_WB: res_src=1, reg_we=1 -> FETCH.
//  - MEM_WR: adr_src=1, mem_we=1 held until mem_ready -> FETCH (retire).
//  - BRANCH: A=rs1, B=rs2, SUB; res_src=0; pc_we = beq zero | bne !zero | blt lt | bge !lt | bltu ltu | bgeu !ltu;
//    funct3 010/011 -> TRAP; else -> FETCH (retire taken or not).
//  - JAL: A=OldPC,B=4 -> rd via ALU_WB path? No: JAL writes rd=OldPC+4 (res_src=2, reg_we=1), then JAL_PC: A=OldPC,B=imm(J), res_src=2, pc_we=1 -> FETCH.
//  - JALR: rd=OldPC+4 as JAL, then JALR_PC: A=rs1, B=imm(I), ADD, pc target LSB cleared by datapath, pc_we=1 -> FETCH.
//    rd written before PC update; rs1 read from register latch captured in DECODE so rd==rs1 is safe.
//  - LUI: res_src=3, imm(U), reg_we=1 -> FETCH. AUIPC: A=OldPC, B=imm(U), ADD -> ALU_WB.
//  - Wait counter: clears on entering any memory state; increments each cycle mem_ready=0;
//    reaching MAX_WAIT with mem_ready=0 -> TRAP(cause 1). mem_ready on that same cycle wins (no trap).
//  - TRAP: trap=1, all strobes 0, state held until rst_n. First cause latched; never overwritten.
//  - instret increments by 1 on the cycle leaving the last state of an instruction; wraps modulo 2^INSTRET_W.
//  - Async reset mid-access drops mem_we/mem_re immediately; no partial retire counted.
// TESTING
//  ADD x3,x1,x2 with mem_ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB; reg_we 1 cycle; instret 0->1 after 4 cycles.
//  LW with mem_ready held low 3 cycles in MEM_RD -> mem_re held, adr_src=1, 3 stall cycles; then MEM_WB reg_we=1.
//  BGEU, ltu=0 -> pc_we=1 in BRANCH; ltu=1 -> pc_we=0; both return to FETCH, instret +1 each.
//  op=0000000 -> TRAP, trap=1 cause=0, no strobe asserted until rst_n low.
//  FETCH with mem_ready=0 for MAX_WAIT=16 cycles -> trap cause=1; variant with mem_ready on cycle 16 -> DECODE, no trap.
//  rst_n low during MEM_WR with mem_we=1 -> mem_we=0 same cycle, state=FETCH, instret=0.

Source files
------------

// File: rtl/multicycle_rv_ctrl.sv
// multicycle_rv_ctrl: multicycle RV32I control FSM with memory wait/timeout, illegal-instruction trap and retire counter
// Ports: clk, rst_n (async active-low); op/funct3/funct7 IR fields; zero/lt/ltu ALU flags;
//   mem_ready memory handshake; pc_we/ir_we/reg_we/mem_we/mem_re/adr_src strobes;
//   res_src/alu_src_a/alu_src_b/alu_op/imm_src datapath selects; trap/cause sticky trap; instret retired count.
module multicycle_rv_ctrl #(
  parameter int MAX_WAIT  = 16,
  parameter int INSTRET_W = 32,
  parameter bit EN_SHIFT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 pc_we,
  output logic                 ir_we,
  output logic                 reg_we,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic                 adr_src,
  output logic [1:0]           res_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_op,
  output logic [2:0]           imm_src,
  output logic                 trap,
  output logic                 cause,
  output logic [INSTRET_W-1:0] instret
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_BRANCH, S_LINK, S_JAL_PC, S_JALR_PC, S_LUI, S_AUIPC, S_TRAP
  } state_e;
  state_e               state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic                 cause_q, cause_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire, mem_st, timeout, shift, r_ok, i_ok, taken, br_ok;
  logic [3:0]           r_op, i_op;
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 4'd1 : 4'd0;
      3'b001:  return 4'd7;
      3'b010:  return 4'd5;
      3'b011:  return 4'd6;
      3'b100:  return 4'd4;
      3'b101:  return alt ? 4'd9 : 4'd8;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction
  assign shift   = funct3[1:0] == 2'b01;
  assign r_ok    = (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                   && (EN_SHIFT || !shift);
  assign i_ok    = (funct3 == 3'b001 ? funct7 == 7'h00 :
                    funct3 == 3'b101 ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1)
                   && (EN_SHIFT || !shift);
  assign r_op    = alu_dec(funct3, funct7[5]);
  // immediate ALU ops only use funct7 to pick SRAI; ADDI never becomes SUB
  assign i_op    = alu_dec(funct3, funct3 == 3'b101 && funct7[5]);
  // funct3[0] inverts the base comparison (bne/bge/bgeu)
  assign taken   = (funct3[2:1] == 2'b00 ? zero : funct3[2:1] == 2'b10 ? lt : ltu) ^ funct3[0];
  assign br_ok   = funct3[2:1] != 2'b01;
  assign mem_st  = state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR;
  assign timeout = mem_st && !mem_ready && wait_q == 8'(MAX_WAIT - 1);
  assign wait_d  = mem_st && !mem_ready ? wait_q + 8'd1 : 8'd0;
  // only memory states can time out, so a trap entered from one records cause 1
  assign cause_d = state_q != S_TRAP && state_d == S_TRAP ? timeout : cause_q;
  assign instret_d = instret_q + INSTRET_W'(retire);
  always_comb begin
    state_d = state_q;
    {pc_we, ir_we, reg_we, mem_we, mem_re, adr_src} = '0;
    res_src = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op = 4'd0;
    imm_src = 3'd0;
    retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        alu_src_b = 2'd2;
        res_src = 2'd2;
        ir_we = mem_ready;
        pc_we = mem_ready;
        state_d = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src = 3'd2;
        case (op)
          7'b0110011:             state_d = r_ok ? S_EXEC_R : S_TRAP;
          7'b0010011:             state_d = i_ok ? S_EXEC_I : S_TRAP;
          7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111, 7'b1100111: state_d = S_LINK;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_AUIPC;
          default:                state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'd2;
        alu_op = r_op;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_op = i_op;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_src = op[5] ? 3'd1 : 3'd0;
        state_d = op[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        adr_src = 1'b1;
        mem_re = 1'b1;
        state_d = mem_ready ? S_MEM_WB : timeout ? S_TRAP : S_MEM_RD;
      end
      S_MEM_WB: begin
        res_src = 2'd1;
        reg_we = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        adr_src = 1'b1;
        mem_we = 1'b1;
        retire = mem_ready;
        state_d = mem_ready ? S_FETCH : timeout ? S_TRAP : S_MEM_WR;
      end
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_op = 4'd1;
        pc_we = br_ok && taken;
        retire = br_ok;
        state_d = br_ok ? S_FETCH : S_TRAP;
      end
      S_LINK: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        res_src = 2'd2;
        reg_we = 1'b1;
        state_d = op[3] ? S_JAL_PC : S_JALR_PC;
      end
      S_JAL_PC: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src = 3'd3;
        res_src = 2'd2;
        pc_we = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_JALR_PC: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        res_src = 2'd2;
        pc_we = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_LUI: begin
        res_src = 2'd3;
        imm_src = 3'd4;
        reg_we = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src = 3'd4;
        state_d = S_ALU_WB;
      end
      default: ;
    endcase
    if (!rst_n) {pc_we, ir_we, reg_we, mem_we, mem_re} = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q <= '0;
      cause_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      cause_q <= cause_d;
      instret_q <= instret_d;
    end
  end
  assign trap = state_q == S_TRAP;
  assign cause = cause_q;
  assign instret = instret_q;
endmodule
